// File: rtl/enc_defines.sv
// Shared constants for the IME register-file arbiter: default widths and the
// one-hot grant encoding used between the arbiter and the top level.
package enc_defines;

    localparam int IME_RF_WORD_WIDTH = 64;
    localparam int IME_RF_ADDR_WIDTH = 5;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_WR   = 2'b01;
    localparam logic [1:0] GNT_RD   = 2'b10;

endpackage

// File: rtl/ime_rf_arb_rr2.sv
// Two-way round-robin arbiter: req[0]/gnt[0] is the write port, req[1]/gnt[1]
// the read port. Last-grant flag resets to "read" so write wins first contention.
module ime_rf_arb_rr2
    import enc_defines::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_rd;

    always_comb begin
        gnt = GNT_NONE;
        if (req[0] && (!req[1] || last_rd)) begin
            gnt = GNT_WR;
        end else if (req[1]) begin
            gnt = GNT_RD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_rd <= 1'b1;
        end else if (gnt != GNT_NONE) begin
            last_rd <= gnt[1];
        end
    end

endmodule

// File: rtl/ime_rf_arb.sv
// Write/read arbiter in front of a single-port register file with a written-flag
// scoreboard. Optional response buffer enabled by macro IME_RF_ARB_RDBUF_EN.
module ime_rf_arb
    import enc_defines::*;
#(
    parameter int WORD_WIDTH = IME_RF_WORD_WIDTH,
    parameter int ADDR_WIDTH = IME_RF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  wr_val_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [WORD_WIDTH-1:0] wr_dat_i,
    output logic                  wr_rdy_o,
    input  logic                  rd_val_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic                  rd_rdy_o,
    output logic                  rd_dat_val_o,
    output logic [WORD_WIDTH-1:0] rd_dat_o,
    output logic                  rd_dat_err_o,
    input  logic                  rd_dat_rdy_i,
    output logic                  rf_cen_o,
    output logic                  rf_wen_o,
    output logic [ADDR_WIDTH-1:0] rf_addr_o,
    output logic [WORD_WIDTH-1:0] rf_dat_o,
    input  logic [WORD_WIDTH-1:0] rf_dat_i
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DEPTH-1:0] written_q;
    logic [1:0]       req;
    logic [1:0]       gnt;
    logic             rd_blocked;
    logic             rd_err_q;
    logic             rf_pend_q;

    // rst gates requests so the RF pins and readies go idle the instant reset rises
    assign req = {rd_val_i & ~clr_i & ~rd_blocked & ~rst,
                  wr_val_i & ~clr_i & ~rst};

    ime_rf_arb_rr2 u_rr2 (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt)
    );

    assign wr_rdy_o = gnt[0];
    assign rd_rdy_o = gnt[1];

    always_comb begin
        rf_cen_o  = 1'b1;
        rf_wen_o  = 1'b1;
        rf_addr_o = '0;
        rf_dat_o  = '0;
        case (gnt)
            GNT_WR: begin
                rf_cen_o  = 1'b0;
                rf_wen_o  = 1'b0;
                rf_addr_o = wr_addr_i;
                rf_dat_o  = wr_dat_i;
            end
            GNT_RD: begin
                rf_cen_o  = 1'b0;
                rf_addr_o = rd_addr_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            written_q <= '0;
            rd_err_q  <= 1'b0;
            rf_pend_q <= 1'b0;
        end else begin
            if (clr_i) begin
                written_q <= '0;
            end else if (gnt == GNT_WR) begin
                written_q[wr_addr_i] <= 1'b1;
            end
            if (gnt == GNT_RD) begin
                rd_err_q <= ~written_q[rd_addr_i];
            end
            rf_pend_q <= (gnt == GNT_RD);
        end
    end

`ifdef IME_RF_ARB_RDBUF_EN
    logic                  buf_val_q;
    logic [WORD_WIDTH-1:0] buf_dat_q;

    assign rd_blocked = (rf_pend_q | buf_val_q) & ~rd_dat_rdy_i;

    // Response is shown straight from the RF in the cycle after the grant and only
    // parked in the register if the consumer stalls, since the RF output may change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_val_q <= 1'b0;
            buf_dat_q <= '0;
        end else if (rf_pend_q && !rd_dat_rdy_i) begin
            buf_val_q <= 1'b1;
            buf_dat_q <= rf_dat_i;
        end else if (buf_val_q && rd_dat_rdy_i) begin
            buf_val_q <= 1'b0;
        end
    end

    assign rd_dat_val_o = rf_pend_q | buf_val_q;
    assign rd_dat_o     = buf_val_q ? buf_dat_q : (rf_pend_q ? rf_dat_i : '0);
`else
    logic unused_rd_dat_rdy;

    assign unused_rd_dat_rdy = rd_dat_rdy_i;
    assign rd_blocked        = 1'b0;
    assign rd_dat_val_o      = rf_pend_q;
    assign rd_dat_o          = rst ? '0 : rf_dat_i;
`endif

    assign rd_dat_err_o = rd_dat_val_o & rd_err_q;

endmodule

// File: tb/tb_ime_rf_arb.sv
// Randomised scoreboard bench for ime_rf_arb with a behavioural RF and reference
// model; works with or without IME_RF_ARB_RDBUF_EN.
module tb_ime_rf_arb;

`ifdef IME_RF_ARB_RDBUF_EN
    localparam bit RDBUF = 1'b1;
`else
    localparam bit RDBUF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr_i = 1'b0;
    logic        wr_val_i = 1'b0;
    logic [4:0]  wr_addr_i = '0;
    logic [63:0] wr_dat_i = '0;
    logic        wr_rdy_o;
    logic        rd_val_i = 1'b0;
    logic [4:0]  rd_addr_i = '0;
    logic        rd_rdy_o;
    logic        rd_dat_val_o;
    logic [63:0] rd_dat_o;
    logic        rd_dat_err_o;
    logic        rd_dat_rdy_i = 1'b1;
    logic        rf_cen_o;
    logic        rf_wen_o;
    logic [4:0]  rf_addr_o;
    logic [63:0] rf_dat_o;
    logic [63:0] rf_dat_i;

    always #5 clk = ~clk;

    ime_rf_arb #(.WORD_WIDTH(64), .ADDR_WIDTH(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (clr_i),
        .wr_val_i     (wr_val_i),
        .wr_addr_i    (wr_addr_i),
        .wr_dat_i     (wr_dat_i),
        .wr_rdy_o     (wr_rdy_o),
        .rd_val_i     (rd_val_i),
        .rd_addr_i    (rd_addr_i),
        .rd_rdy_o     (rd_rdy_o),
        .rd_dat_val_o (rd_dat_val_o),
        .rd_dat_o     (rd_dat_o),
        .rd_dat_err_o (rd_dat_err_o),
        .rd_dat_rdy_i (rd_dat_rdy_i),
        .rf_cen_o     (rf_cen_o),
        .rf_wen_o     (rf_wen_o),
        .rf_addr_o    (rf_addr_o),
        .rf_dat_o     (rf_dat_o),
        .rf_dat_i     (rf_dat_i)
    );

    // Single-port RF, one-cycle read latency; read output held between reads.
    logic [63:0] rf_mem [32];
    logic [63:0] rf_q = '0;
    assign rf_dat_i = rf_q;
    always @(posedge clk) begin
        if (!rf_cen_o) begin
            if (!rf_wen_o) rf_mem[rf_addr_o] <= rf_dat_o;
            else           rf_q <= rf_mem[rf_addr_o];
        end
    end

    // Reference model state
    typedef struct { logic [63:0] dat; logic err; } rsp_t;
    logic [63:0] ref_mem [32];
    bit          ref_wr  [32];
    bit          last_rd;
    rsp_t        exp_q [$];

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) ref_wr[i] = 1'b0;
        last_rd = 1'b1;
        exp_q.delete();
    endtask

    // Drive one cycle of requests, then check readies and RF pins against the model.
    task automatic cycle(input bit wv, input logic [4:0] wa, input logic [63:0] wd,
                         input bit rv, input logic [4:0] ra, input bit clr, input bit drdy);
        bit w_ok, r_ok, exp_w, exp_r;
        @(posedge clk); #1;
        wr_val_i = wv; wr_addr_i = wa; wr_dat_i = wd;
        rd_val_i = rv; rd_addr_i = ra; clr_i = clr; rd_dat_rdy_i = drdy;
        @(negedge clk);
        w_ok  = wv && !clr;
        r_ok  = rv && !clr && (!RDBUF || exp_q.size() == 0 || drdy);
        exp_w = w_ok && (!r_ok || last_rd);
        exp_r = r_ok && !exp_w;
        chk("wr_rdy", {63'd0, wr_rdy_o}, {63'd0, exp_w});
        chk("rd_rdy", {63'd0, rd_rdy_o}, {63'd0, exp_r});
        chk("rf_cen", {63'd0, rf_cen_o}, {63'd0, !(exp_w || exp_r)});
        if (exp_w) begin
            chk("rf_wen_w", {63'd0, rf_wen_o}, 64'd0);
            chk("rf_addr_w", {59'd0, rf_addr_o}, {59'd0, wa});
            chk("rf_dat_w", rf_dat_o, wd);
            ref_mem[wa] = wd;
            ref_wr[wa]  = 1'b1;
            last_rd     = 1'b0;
        end else if (exp_r) begin
            chk("rf_wen_r", {63'd0, rf_wen_o}, 64'd1);
            chk("rf_addr_r", {59'd0, rf_addr_o}, {59'd0, ra});
            exp_q.push_back('{dat: ref_mem[ra], err: !ref_wr[ra]});
            last_rd = 1'b1;
        end
        if (clr) for (int i = 0; i < 32; i++) ref_wr[i] = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        wr_val_i = 1'b1; rd_val_i = 1'b1; wr_addr_i = 5'd9; rd_addr_i = 5'd9;
        wr_dat_i = 64'hFFFF_0000_FFFF_0000; clr_i = 1'b0; rd_dat_rdy_i = 1'b1;
        model_reset();
        #1;
        chk("rst_wr_rdy", {63'd0, wr_rdy_o}, 64'd0);
        chk("rst_rd_rdy", {63'd0, rd_rdy_o}, 64'd0);
        chk("rst_rd_val", {63'd0, rd_dat_val_o}, 64'd0);
        chk("rst_rd_err", {63'd0, rd_dat_err_o}, 64'd0);
        chk("rst_rd_dat", rd_dat_o, 64'd0);
        chk("rst_cen", {63'd0, rf_cen_o}, 64'd1);
        chk("rst_wen", {63'd0, rf_wen_o}, 64'd1);
        chk("rst_addr", {59'd0, rf_addr_o}, 64'd0);
        chk("rst_dat", rf_dat_o, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        wr_val_i = 1'b0; rd_val_i = 1'b0;
        rst = 1'b0;
    endtask

    // Monitor: compares every presented response against the queue head; pops on accept.
    always begin
        @(negedge clk); #2;
        if (!rst && rd_dat_val_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", {63'd0, rd_dat_val_o}, 64'd0);
            end else begin
                chk("rsp_dat", rd_dat_o, exp_q[0].dat);
                chk("rsp_err", {63'd0, rd_dat_err_o}, {63'd0, exp_q[0].err});
                if (!RDBUF || rd_dat_rdy_i) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [5:0] seq;
        for (int i = 0; i < 32; i++) begin
            rf_mem[i]  = '0;
            ref_mem[i] = '0;
        end
        model_reset();
        do_reset();

        // First write after reset drives the RF in the same cycle
        cycle(1, 5'd3, 64'h0123_4567_89AB_CDEF, 0, 5'd0, 0, 1);
        chk("w3_rdy", {63'd0, wr_rdy_o}, 64'd1);
        chk("w3_cen", {63'd0, rf_cen_o}, 64'd0);
        chk("w3_wen", {63'd0, rf_wen_o}, 64'd0);
        chk("w3_addr", {59'd0, rf_addr_o}, 64'd3);
        cycle(0, 5'd0, 64'd0, 1, 5'd3, 0, 1);
        cycle(0, 5'd0, 64'd0, 0, 5'd0, 0, 1);
        chk("r3_val", {63'd0, rd_dat_val_o}, 64'd1);
        chk("r3_dat", rd_dat_o, 64'h0123_4567_89AB_CDEF);
        chk("r3_err", {63'd0, rd_dat_err_o}, 64'd0);
        cycle(0, 5'd0, 64'd0, 1, 5'd7, 0, 1);
        cycle(0, 5'd0, 64'd0, 0, 5'd0, 0, 1);
        chk("r7_err", {63'd0, rd_dat_err_o}, 64'd1);
        cycle(1, 5'd4, 64'd55, 1, 5'd3, 1, 1);
        cycle(0, 5'd0, 64'd0, 1, 5'd3, 0, 1);
        cycle(0, 5'd0, 64'd0, 0, 5'd0, 0, 1);
        chk("clr_r3_err", {63'd0, rd_dat_err_o}, 64'd1);

        // Contention from reset: W,R,W,R,W,R
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(1, 5'(i + 10), 64'(i * 3 + 1), 1, 5'(i), 0, 1);
            seq[i] = wr_rdy_o;
        end
        chk("rr_seq", {58'd0, seq}, 64'b010101);
        cycle(0, 5'd0, 64'd0, 0, 5'd0, 0, 1);

        if (RDBUF) begin
            cycle(0, 5'd0, 64'd0, 1, 5'd10, 0, 0);
            for (int i = 0; i < 4; i++) cycle(0, 5'd0, 64'd0, 1, 5'd12, 0, 0);
            cycle(0, 5'd0, 64'd0, 1, 5'd12, 0, 1);
            chk("stall_release_rdy", {63'd0, rd_rdy_o}, 64'd1);
            cycle(0, 5'd0, 64'd0, 0, 5'd0, 0, 1);
        end

        for (int n = 0; n < 400; n++) begin
            cycle(bit'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  {$urandom, $urandom}, bit'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 3) != 0));
        end
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) cycle(0, 5'd0, 64'd0, 0, 5'd0, 0, 1);
        chk("drain", 64'(exp_q.size()), 64'd0);

        // Reset one cycle after a read grant discards the response
        cycle(0, 5'd0, 64'd0, 1, 5'd3, 0, 1);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(0, 5'd0, 64'd0, 0, 5'd0, 0, 1);
            chk("post_rst_val", {63'd0, rd_dat_val_o}, 64'd0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ime_rf_arb.md
IME_RF_ARB -- requirements
Module: ime_rf_arb

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous reset, active-high.
REQ-003 SHALL have ports: clr_i  in  1  sync pulse, clears written-flag scoreboard.
REQ-004 SHALL have ports: wr_val_i in 1, wr_addr_i in 5, wr_dat_i in 64, wr_rdy_o out 1  (write request, valid/ready).
REQ-005 SHALL have ports: rd_val_i in 1, rd_addr_i in 5, rd_rdy_o out 1  (read request, valid/ready).
REQ-006 SHALL have ports: rd_dat_val_o out 1, rd_dat_o out 64, rd_dat_err_o out 1, rd_dat_rdy_i in 1  (read response).
REQ-007 SHALL have ports: rf_cen_o out 1 (active-low), rf_wen_o out 1 (active-low write), rf_addr_o out 5, rf_dat_o out 64, rf_dat_i in 64  (to 1-port 64x32 RF, 1-cycle read latency).
REQ-008 Parameters SHALL be: WORD_WIDTH default 64, data width; ADDR_WIDTH default 5, address width (depth 2^ADDR_WIDTH).

Function
REQ-009 Request accepted at edge E when val&rdy; at most one grant per cycle.
REQ-010 Grant drives RF combinationally in the same cycle: rf_cen_o=0, rf_wen_o=0 for write / 1 for read, rf_addr_o and rf_dat_o from granted requester; idle: rf_cen_o=1, rf_wen_o=1, addr/data 0.
REQ-011 Only one requester valid: that requester granted. Both valid: round-robin, requester not granted last wins; last-grant flag resets to "read" so write wins first contention.
REQ-012 clr_i=1: wr_rdy_o=rd_rdy_o=0 that cycle; all 32 written flags cleared at edge.
REQ-013 Write grant sets written flag of wr_addr_i at edge E.
REQ-014 Read granted at E: rd_dat_val_o=1 in cycle after E, rd_dat_o = RF data, rd_dat_err_o = inverse of the address's written flag sampled at E.
REQ-015 Write at E followed by read of same address granted at E+1 SHALL return new data, err=0.
REQ-016 Ready generation SHALL be combinational from val inputs, clr_i and response state only; no combinational path from rf_dat_i to any ready.

Reset
REQ-017 Asserted rst SHALL immediately force: wr_rdy_o=0, rd_rdy_o=0, rd_dat_val_o=0, rd_dat_err_o=0, rd_dat_o=0, rf_cen_o=1, rf_wen_o=1, rf_addr_o=0, rf_dat_o=0; all written flags 0; last-grant=read.
REQ-018 Reset mid-transaction SHALL discard any pending response; no rd_dat_val_o after release.

Configuration
REQ-019 Macro IME_RF_ARB_RDBUF_EN defined: response captured in a 64-bit output register; rd_dat_val_o held with stable data/err until rd_dat_rdy_i=1; rd_rdy_o=0 while a response is pending and not being accepted that cycle (accept and new grant in same cycle allowed).
REQ-020 Macro undefined: no output register; rd_dat_o = rf_dat_i pass-through, rd_dat_val_o is a 1-cycle pulse, rd_dat_rdy_i ignored, rd_rdy_o never blocked by response.

Structure
REQ-021 Shared package (enc_defines) SHALL hold IME_RF_WORD_WIDTH=64, IME_RF_ADDR_WIDTH=5 and the grant encoding constants (GNT_NONE, GNT_WR, GNT_RD).
REQ-022 Round-robin two-way arbiter SHALL be sub-module ime_rf_arb_rr2 (req[1:0] in, gnt[1:0] out, last-grant state inside); scoreboard and response path stay in top.
REQ-023 RF itself SHALL be instantiated outside this block.

Verification
REQ-024 Reset release, write val addr 3 data 0x0123456789ABCDEF -> rf_cen_o=0, rf_wen_o=0, rf_addr_o=3 same cycle; wr_rdy_o=1.
REQ-025 Write addr 3 at E, read addr 3 at E+1 -> rd_dat_val_o at E+2 cycle, rd_dat_o=0x0123456789ABCDEF, rd_dat_err_o=0.
REQ-026 Read addr 7 never written -> rd_dat_val_o=1, rd_dat_err_o=1; after clr_i, read addr 3 -> err=1.
REQ-027 Both val held high 6 cycles -> grants W,R,W,R,W,R; no cycle with both rdy high.
REQ-028 RDBUF_EN, rd_dat_rdy_i=0 for 4 cycles -> rd_dat_o stable, rd_rdy_o=0, next read granted in cycle rd_dat_rdy_i=1.
REQ-029 rst pulsed one cycle after read grant -> rd_dat_val_o stays 0, rf_cen_o=1 during and after reset.
